// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (fetch / data) arbiter in front of a single-ported
//            memory. Data normally wins. A starvation counter hands priority
//            to fetch after STARVE_LIMIT data grants made while fetch waits.
//            Every output is registered.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    // memory port
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    // status
    output logic        busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t          state_q,    state_d;
    logic            m_req_q,    m_req_d;
    logic            m_we_q,     m_we_d;
    logic [31:0]     m_addr_q,   m_addr_d;
    logic [31:0]     m_wdata_q,  m_wdata_d;
    logic            if_ack_q,   if_ack_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic            d_ack_q,    d_ack_d;
    logic [31:0]     d_rdata_q,  d_rdata_d;
    logic            busy_q,     busy_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    logic            arb_en;
    logic            if_cand;
    logic            d_cand;
    logic            fetch_pri;

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_ack_d    = 1'b0;
        d_rdata_d  = d_rdata_q;
        busy_d     = busy_q;
        wait_cnt_d = wait_cnt_q;

        // The ack cycle is the mandatory idle gap: the acked requester may
        // still be holding req, and skipping arbitration here lets a
        // requester that re-issues straight after its ack compete fairly.
        arb_en    = !if_ack_q && !d_ack_q;
        if_cand   = if_req && arb_en;
        d_cand    = d_req  && arb_en;
        fetch_pri = (wait_cnt_q == LIMIT);

        case (state_q)
            ST_IDLE: begin
                if (if_cand && (!d_cand || fetch_pri)) begin
                    state_d    = ST_FETCH;
                    m_req_d    = 1'b1;
                    m_we_d     = 1'b0;
                    m_addr_d   = if_addr;
                    m_wdata_d  = 32'd0;
                    busy_d     = 1'b1;
                    wait_cnt_d = '0;
                end else if (d_cand) begin
                    state_d   = ST_DATA;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    busy_d    = 1'b1;
                    if (if_req && (wait_cnt_q != LIMIT)) begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
                end
            end
            ST_FETCH, ST_DATA: begin
                // m_* stay frozen until the memory completes.
                if (m_ack) begin
                    state_d = ST_IDLE;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    busy_d  = 1'b0;
                    if (state_q == ST_FETCH) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = m_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                m_req_d = 1'b0;
                m_we_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'd0;
            m_wdata_q  <= 32'd0;
            if_ack_q   <= 1'b0;
            if_rdata_q <= 32'd0;
            d_ack_q    <= 1'b0;
            d_rdata_q  <= 32'd0;
            busy_q     <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ack_q   <= if_ack_d;
            if_rdata_q <= if_rdata_d;
            d_ack_q    <= d_ack_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= busy_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_ack   = if_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_ack    = d_ack_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        busy;

    int total  = 0;
    int passed = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int acks = 0;
        total++;
        if ({m_req, m_we, busy, if_ack, d_ack} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {m_req, m_we, busy, if_ack, d_ack});
        else passed++;
        total++;
        if ({m_addr, m_wdata, if_rdata, d_rdata} !== 128'd0)
            $display("FAIL reset_data got %h want 0", {m_addr, m_wdata, if_rdata, d_rdata});
        else passed++;
        total++;
        if (dut.wait_cnt_q !== 3'd0) $display("FAIL reset_wait_cnt got %0d want 0", dut.wait_cnt_q);
        else passed++;
        // stray m_ack in IDLE must do nothing
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        if (if_ack || d_ack || busy) acks++;
        step();
        if (if_ack || d_ack || busy) acks++;
        total++;
        if (acks !== 0 || dut.state_q !== 2'd0)
            $display("FAIL idle_m_ack got %0d events state %0d want 0 events state 0", acks, dut.state_q);
        else passed++;
    endtask

    task automatic test_single_fetch();
        int busy_cnt = 0, mreq_cnt = 0, ack_cnt = 0, ack_at = 0;
        if_addr = 32'h10; if_req = 1'b1; m_rdata = 32'hDEADBEEF;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (busy)  busy_cnt++;
            if (m_req) mreq_cnt++;
            if (if_ack) begin ack_cnt++; ack_at = i; if_req = 1'b0; end
            if (i == 1) begin
                total++;
                if (m_addr !== 32'h10 || m_we !== 1'b0 || m_wdata !== 32'd0)
                    $display("FAIL fetch_grant got addr %h we %b wdata %h want 10 0 0", m_addr, m_we, m_wdata);
                else passed++;
            end
            m_ack = (i == 4);
        end
        total++;
        if (busy_cnt !== 4) $display("FAIL fetch_busy got %0d want 4", busy_cnt); else passed++;
        total++;
        if (mreq_cnt !== 4) $display("FAIL fetch_mreq got %0d want 4", mreq_cnt); else passed++;
        total++;
        if (ack_cnt !== 1 || ack_at !== 5)
            $display("FAIL fetch_ack got %0d at %0d want 1 at 5", ack_cnt, ack_at);
        else passed++;
        total++;
        if (if_rdata !== 32'hDEADBEEF) $display("FAIL fetch_rdata got %h want deadbeef", if_rdata);
        else passed++;
    endtask

    task automatic test_load();
        int ack_at = 0, if_acks = 0;
        d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'd0; d_req = 1'b1; m_rdata = 32'hCAFEF00D;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (d_ack) begin ack_at = i; d_req = 1'b0; end
            if (if_ack) if_acks++;
            if (i == 1) begin
                total++;
                if (m_addr !== 32'h80 || m_we !== 1'b0)
                    $display("FAIL load_grant got addr %h we %b want 80 0", m_addr, m_we);
                else passed++;
            end
            m_ack = (i == 1);
        end
        total++;
        if (ack_at !== 2 || if_acks !== 0)
            $display("FAIL load_ack got d_ack at %0d if_acks %0d want 2 0", ack_at, if_acks);
        else passed++;
        total++;
        if (d_rdata !== 32'hCAFEF00D) $display("FAIL load_rdata got %h want cafef00d", d_rdata);
        else passed++;
    endtask

    task automatic test_store();
        int ack_at = 0;
        d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_req = 1'b1; m_rdata = 32'h55555555;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (d_ack) begin ack_at = i; d_req = 1'b0; end
            if (i == 1) begin
                total++;
                if (m_we !== 1'b1 || m_addr !== 32'h40 || m_wdata !== 32'h12345678)
                    $display("FAIL store_grant got we %b addr %h wdata %h want 1 40 12345678", m_we, m_addr, m_wdata);
                else passed++;
            end
            m_ack = (i == 2);
        end
        total++;
        if (ack_at !== 3) $display("FAIL store_ack got %0d want 3", ack_at); else passed++;
        total++;
        if (d_rdata !== 32'hCAFEF00D) $display("FAIL store_rdata_kept got %h want cafef00d", d_rdata);
        else passed++;
    endtask

    task automatic test_contention();
        logic [31:0] g_addr [4];
        int          g_wc   [4];
        int          g = 0;
        logic        prev = 1'b0;
        if_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (m_req && !prev && g < 4) begin g_addr[g] = m_addr; g_wc[g] = int'(dut.wait_cnt_q); g++; end
            prev = m_req;
            if (d_ack)  d_req  = 1'b0;
            if (if_ack) if_req = 1'b0;
            m_ack   = m_req && !m_ack;
            m_rdata = 32'hA000_0000 | m_addr;
        end
        total++;
        if (g !== 2) $display("FAIL cont_grants got %0d want 2", g); else passed++;
        total++;
        if (g_addr[0] !== 32'h200 || g_wc[0] !== 1)
            $display("FAIL cont_first got %h wc %0d want 200 wc 1", g_addr[0], g_wc[0]);
        else passed++;
        total++;
        if (g_addr[1] !== 32'h100 || g_wc[1] !== 0)
            $display("FAIL cont_second got %h wc %0d want 100 wc 0", g_addr[1], g_wc[1]);
        else passed++;
        total++;
        if (if_rdata !== 32'hA000_0100 || d_rdata !== 32'hA000_0200)
            $display("FAIL cont_rdata got %h %h want a0000100 a0000200", if_rdata, d_rdata);
        else passed++;
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr [5] = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h300};
        int          exp_wc   [5] = '{1, 2, 3, 4, 0};
        logic [31:0] g_addr   [8];
        int          g_wc     [8];
        int          g = 0, seq = 0;
        logic        prev = 1'b0, done = 1'b0;
        if_addr = 32'h300; if_req = 1'b1;
        d_we = 1'b0; d_addr = 32'h400; d_req = 1'b1;
        for (int i = 1; i <= 80 && !done; i++) begin
            step();
            if (m_req && !prev && g < 8) begin g_addr[g] = m_addr; g_wc[g] = int'(dut.wait_cnt_q); g++; end
            prev = m_req;
            if (d_ack) begin seq++; d_addr = 32'h400 + 32'(seq * 4); end
            if (if_ack) begin done = 1'b1; if_req = 1'b0; d_req = 1'b0; end
            m_ack   = m_req && !m_ack;
            m_rdata = 32'hB000_0000 | m_addr;
        end
        m_ack = 1'b0;
        step();
        total++;
        if (!done) $display("FAIL starve_timeout got no if_ack want if_ack within 80 cycles"); else passed++;
        total++;
        if (g !== 5) $display("FAIL starve_grants got %0d want 5", g); else passed++;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (k >= g || g_addr[k] !== exp_addr[k] || g_wc[k] !== exp_wc[k])
                $display("FAIL starve_grant%0d got %h wc %0d want %h wc %0d", k, g_addr[k], g_wc[k], exp_addr[k], exp_wc[k]);
            else passed++;
        end
        total++;
        if (dut.wait_cnt_q !== 3'd0) $display("FAIL starve_wc_end got %0d want 0", dut.wait_cnt_q); else passed++;
    endtask

    task automatic test_reset_mid_data();
        int acks = 0;
        d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'hAA; d_req = 1'b1;
        step();
        total++;
        if (m_req !== 1'b1) $display("FAIL rmid_grant got m_req %b want 1", m_req); else passed++;
        reset = 1'b1; d_req = 1'b0;
        step();
        reset = 1'b0;
        if (d_ack) acks++;
        step();
        if (d_ack) acks++;
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        if (d_ack) acks++;
        step();
        if (d_ack) acks++;
        total++;
        if (acks !== 0) $display("FAIL rmid_no_ack got %0d acks want 0", acks); else passed++;
        total++;
        if (dut.state_q !== 2'd0) $display("FAIL rmid_state got %0d want 0", dut.state_q); else passed++;
        total++;
        if ({m_req, m_we, busy, if_ack, d_ack, m_addr, m_wdata, if_rdata, d_rdata} !== 133'd0)
            $display("FAIL rmid_outputs got %b %b %b %h %h %h %h want all zero",
                     m_req, m_we, busy, m_addr, m_wdata, if_rdata, d_rdata);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] g_addr [4];
        int          g = 0, acks = 0;
        logic        prev = 1'b0, move = 1'b0;
        if_addr = 32'h10; if_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (move) begin if_addr = 32'h14; move = 1'b0; end
            if (m_req && !prev && g < 4) begin g_addr[g] = m_addr; g++; end
            prev = m_req;
            if (if_ack) begin
                acks++;
                if (acks == 1) move = 1'b1;
                else if_req = 1'b0;
            end
            m_ack   = m_req && !m_ack;
            m_rdata = 32'hC000_0000 | m_addr;
        end
        total++;
        if (g !== 2 || acks !== 2) $display("FAIL b2b_count got %0d grants %0d acks want 2 2", g, acks);
        else passed++;
        total++;
        if (g_addr[0] !== 32'h10 || g_addr[1] !== 32'h14)
            $display("FAIL b2b_addr got %h %h want 10 14", g_addr[0], g_addr[1]);
        else passed++;
        total++;
        if (if_rdata !== 32'hC000_0014) $display("FAIL b2b_rdata got %h want c0000014", if_rdata);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_single_fetch();
        test_load();
        test_store();
        test_contention();
        test_starvation();
        test_reset_mid_data();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, sets how many consecutive data grants may occur while a fetch waits before fetch gains priority.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch request; held high with stable if_addr until if_ack.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_ack  output  1  one-cycle pulse; if_rdata valid in that cycle.
REQ-007 if_rdata  output  32  fetched word, registered.
REQ-008 d_req  input  1  data request; held high with stable d_we/d_addr/d_wdata until d_ack.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_ack  output  1  one-cycle completion pulse for load or store.
REQ-013 d_rdata  output  32  load data, registered; valid when d_ack and d_we was 0.
REQ-014 m_req  output  1  memory request; held high until m_ack.
REQ-015 m_we  output  1  memory write enable.
REQ-016 m_addr  output  32  memory byte address.
REQ-017 m_wdata  output  32  memory write data.
REQ-018 m_ack  input  1  memory completion, one cycle; variable latency of at least 1 cycle after m_req rises.
REQ-019 m_rdata  input  32  read data, valid with m_ack.
REQ-020 busy  output  1  high in FETCH or DATA state.

Function
REQ-021 FSM states: IDLE, FETCH, DATA; all outputs are registered.
REQ-022 IDLE: candidate ports are those with req high and their ack not asserted in the current cycle.
REQ-023 Port selection with both ports candidate: data wins unless wait_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-024 Port selection with one candidate: that port wins.
REQ-025 On grant: latch the winner's address/we/wdata into m_addr/m_we/m_wdata, assert m_req, and move to FETCH or DATA; m_req is high the cycle after the request is sampled.
REQ-026 Fetch grants always drive m_we=0 and m_wdata=0.
REQ-027 FETCH/DATA: hold m_* stable while m_ack is low.
REQ-028 On m_ack in FETCH/DATA: next cycle m_req=0, the owning ack pulses for one cycle, rdata is captured from m_rdata (if_rdata for FETCH; d_rdata for DATA loads only, unchanged on stores), and the state returns to IDLE.
REQ-029 Minimum spacing is one IDLE cycle between memory transactions; m_req is low for at least one cycle between grants.
REQ-030 wait_cnt (width clog2(STARVE_LIMIT+1)) increments, saturating at STARVE_LIMIT, on each data grant made while if_req is high.
REQ-031 wait_cnt clears to 0 on each fetch grant.
REQ-032 m_ack received in IDLE is ignored, with no ack pulse and no state change.
REQ-033 Request inputs are ignored while in FETCH or DATA; there is no queuing and no preemption.
REQ-034 Every req is eventually acked, given that m_ack eventually arrives; the fetch wait is bounded by STARVE_LIMIT+1 data transactions.

Reset
REQ-035 On reset, the state is IDLE; m_req, m_we, if_ack, d_ack and busy are 0; m_addr, m_wdata, if_rdata and d_rdata are 0; wait_cnt is 0.
REQ-036 Reset in FETCH/DATA abandons the transaction: no ack is issued, and a subsequent stale m_ack is ignored per REQ-032.
REQ-037 Reset has priority over every other event in the same cycle.

Verification
REQ-038 Single fetch: if_req=1 with if_addr=0x10, memory acks 3 cycles after m_req, m_rdata=0xDEADBEEF -> m_addr=0x10, m_we=0, if_ack for one cycle, if_rdata=0xDEADBEEF, busy high for 4 cycles.
REQ-039 Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> m_we=1, m_addr=0x40, m_wdata=0x12345678, d_ack one cycle after m_ack, d_rdata unchanged.
REQ-040 Contention: if_req and d_req both high from the same cycle -> data granted first, fetch granted on the next IDLE arbitration, wait_cnt goes 0->1->0.
REQ-041 Starvation: if_req held high while d_req is reissued immediately after every d_ack, STARVE_LIMIT=4 -> exactly 4 data grants, then a fetch grant, then wait_cnt=0.
REQ-042 Reset mid-DATA: reset pulsed while m_req=1, then m_ack pulsed 2 cycles later -> no d_ack, state IDLE, all outputs at reset values.
REQ-043 Back-to-back: requester holds if_req high through the if_ack cycle with a new if_addr=0x14 from the next cycle -> no duplicate grant of 0x10 in the ack cycle, and the second m_req has m_addr=0x14.
